// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (if_*) and load/store (dm_*) requesters.
// Optional build macro ARB_ROUND_ROBIN_EN swaps fixed dm priority for round-robin on collisions.
module mem_port_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1    // legal range 1..7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       own_dm;
    logic       we_q;
    logic       any_req;
    logic       pick_dm;

    assign any_req = if_req | dm_req;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = dm was the last requester granted; a collision goes to the other side.
    logic last_dm;

    assign pick_dm = dm_req & ~(if_req & last_dm);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_dm <= 1'b0;
        else if (state == IDLE && any_req)
            last_dm <= pick_dm;
    end
`else
    assign pick_dm = dm_req;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = WAIT;
            WAIT:    if (cnt == 3'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own_dm    <= 1'b0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= 3'd0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        own_dm    <= pick_dm;
                        we_q      <= pick_dm & dm_we;
                        mem_addr  <= pick_dm ? dm_addr : if_addr;
                        mem_wdata <= pick_dm ? dm_wdata : '0;
                    end
                end
                ACCESS: cnt <= LAT_M1;
                WAIT: begin
                    // Counter at zero marks the edge where the memory word is valid.
                    if (cnt == 3'd0) begin
                        if (!we_q) begin
                            if (own_dm)
                                dm_rdata <= mem_rdata;
                            else
                                if_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_en  = (state == ACCESS);
    assign mem_we  = mem_en & we_q;
    assign if_gnt  = mem_en & ~own_dm;
    assign dm_gnt  = mem_en & own_dm;
    assign if_done = (state == RESP) & ~own_dm;
    assign dm_done = (state == RESP) & own_dm;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: three instances at MEM_LAT 1, 3 and 4, each
// with its own random requesters, transaction-level reference model and monitor.
module tb_mem_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;

    typedef struct {
        bit             own_dm;
        bit             we;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [DW-1:0]  rdata;
        int             cyc;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input int b, input string nm, input bit ok,
                         input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL blk%0d %s: actual %0h required %0h", b, nm, act, req);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {8'hA5, a} ^ 32'h0F0F_0000;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : blk
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

        logic          rst, if_req, if_gnt, if_done, dm_req, dm_we, dm_gnt, dm_done;
        logic          mem_en, mem_we, busy;
        logic [AW-1:0] if_addr, dm_addr, mem_addr;
        logic [DW-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;

        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
            .if_rdata(if_rdata),
            .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
            .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata), .busy(busy)
        );

        int            cyc = 0;
        txn_t          q[$];
        logic [DW-1:0] ref_mem[logic [AW-1:0]];
        logic [DW-1:0] env_mem[logic [AW-1:0]];
        int            last_gnt = -100;
        int            free_at = 0;
        bit            rr_last_dm = 1'b0;
        bit            fin = 1'b0;

        // Reference model: an idle port takes one request per access; the next one is
        // considered LAT+3 cycles after a grant.
        initial begin
            txn_t t;
            bit   pdm;
            forever begin
                @(posedge clk);
                cyc++;
                if (!rst) begin
                    free_at = 0; last_gnt = -100; rr_last_dm = 1'b0;
                end else if (cyc >= free_at && (if_req || dm_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (if_req && dm_req) pdm = !rr_last_dm;
                    else                  pdm = dm_req;
                    rr_last_dm = pdm;
`else
                    pdm = dm_req;
`endif
                    t.own_dm = pdm;
                    t.we     = pdm && dm_we;
                    t.addr   = pdm ? dm_addr : if_addr;
                    t.wdata  = dm_wdata;
                    t.cyc    = cyc;
                    t.rdata  = ref_mem.exists(t.addr) ? ref_mem[t.addr] : init_word(t.addr);
                    if (t.we) ref_mem[t.addr] = t.wdata;
                    q.push_back(t);
                    last_gnt = cyc;
                    free_at  = cyc + LAT + 3;
                end
            end
        end

        // Memory: read word is driven only in the cycle before the capture edge.
        initial begin
            bit            pend;
            int            due;
            logic [DW-1:0] pend_data;
            pend = 1'b0; due = 0; pend_data = '0; mem_rdata = '0;
            forever begin
                @(negedge clk); #1;
                if (!rst) pend = 1'b0;
                else if (mem_en) begin
                    if (mem_we) env_mem[mem_addr] = mem_wdata;
                    else begin
                        pend = 1'b1; due = cyc + LAT;
                        pend_data = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_word(mem_addr);
                    end
                end
                if (pend && cyc == due) begin
                    mem_rdata = pend_data; pend = 1'b0;
                end else begin
                    mem_rdata = $urandom;
                end
            end
        end

        // Monitor
        initial begin
            txn_t          t;
            logic [DW-1:0] exp_if_rd, exp_dm_rd, wd_act, wd_exp;
            exp_if_rd = '0; exp_dm_rd = '0;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    check(g, "reset_outputs",
                          {if_gnt, if_done, dm_gnt, dm_done, mem_en, mem_we, busy,
                           mem_addr, mem_wdata, if_rdata, dm_rdata} == '0,
                          {if_gnt, if_done, dm_gnt, dm_done, mem_en, mem_we, busy,
                           mem_addr, mem_wdata, if_rdata, dm_rdata}, 0);
                    q.delete(); exp_if_rd = '0; exp_dm_rd = '0;
                end else begin
                    if (if_gnt || dm_gnt || mem_en) begin
                        if (q.size() == 0) begin
                            check(g, "gnt_unexpected", 1'b0, {if_gnt, dm_gnt, mem_en}, 0);
                        end else begin
                            t = q[0];
                            check(g, "gnt_cycle", cyc == t.cyc, cyc, t.cyc);
                            check(g, "gnt_owner", {if_gnt, dm_gnt, mem_en} == {!t.own_dm, t.own_dm, 1'b1},
                                  {if_gnt, dm_gnt, mem_en}, {!t.own_dm, t.own_dm, 1'b1});
                            wd_act = t.we ? mem_wdata : '0;
                            wd_exp = t.we ? t.wdata : '0;
                            check(g, "mem_access", {mem_we, mem_addr, wd_act} == {t.we, t.addr, wd_exp},
                                  {mem_we, mem_addr, wd_act}, {t.we, t.addr, wd_exp});
                        end
                    end
                    if (if_done || dm_done) begin
                        if (q.size() == 0) begin
                            check(g, "done_unexpected", 1'b0, {if_done, dm_done}, 0);
                        end else begin
                            t = q.pop_front();
                            check(g, "done_cycle", cyc == t.cyc + LAT + 1, cyc, t.cyc + LAT + 1);
                            check(g, "done_owner", {if_done, dm_done} == {!t.own_dm, t.own_dm},
                                  {if_done, dm_done}, {!t.own_dm, t.own_dm});
                            if (!t.we) begin
                                if (t.own_dm) exp_dm_rd = t.rdata;
                                else          exp_if_rd = t.rdata;
                            end
                        end
                    end else if (q.size() > 0 && cyc > q[0].cyc + LAT + 1) begin
                        check(g, "done_timeout", 1'b0, cyc, q[0].cyc + LAT + 1);
                        void'(q.pop_front());
                    end
                    check(g, "if_rdata", if_rdata == exp_if_rd, if_rdata, exp_if_rd);
                    check(g, "dm_rdata", dm_rdata == exp_dm_rd, dm_rdata, exp_dm_rd);
                    check(g, "busy", busy == (cyc >= last_gnt && cyc <= last_gnt + LAT + 1),
                          busy, (cyc >= last_gnt && cyc <= last_gnt + LAT + 1));
                end
            end
        end

        task automatic step();
            @(negedge clk); #1;
        endtask

        task automatic drain();
            for (int i = 0; i < 60 && (if_req || dm_req); i++) begin
                step();
                if (if_gnt) if_req = 1'b0;
                if (dm_gnt) dm_req = 1'b0;
            end
            check(g, "req_timeout", !(if_req || dm_req), {if_req, dm_req}, 0);
        endtask

        task automatic wait_idle();
            for (int i = 0; i < 40 && busy; i++) step();
            check(g, "idle_timeout", !busy, busy, 0);
            step();
        endtask

        // Requesters
        initial begin
            int ngnt;
            rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
            if_addr = '0; dm_addr = '0; dm_wdata = '0;
            if (g == 0) begin
                ref_mem[24'h000010] = 32'hDEADBEEF;
                env_mem[24'h000010] = 32'hDEADBEEF;
            end
            #1 rst = 1'b0;
            repeat (3) step();
            rst = 1'b1;
            step();
            if (g == 0) begin
                if_req = 1'b1; if_addr = 24'h000010;
                drain(); wait_idle();
                dm_req = 1'b1; dm_we = 1'b1; dm_addr = 24'h000004; dm_wdata = 32'h12345678;
                drain();
                // one-cycle data request while busy, withdrawn before the port frees up
                dm_we = 1'b0; dm_addr = 24'h000009; dm_req = 1'b1;
                step(); dm_req = 1'b0;
                wait_idle();
                if_req = 1'b1; if_addr = 24'h000008;
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 24'h000004;
                drain(); wait_idle();
            end else if (g == 1) begin
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 24'h000005;
                drain(); wait_idle();
                if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
                ngnt = 0;
                for (int i = 0; i < 80 && ngnt < 3; i++) begin
                    step();
                    if (if_gnt || dm_gnt) begin
                        ngnt++;
                        if_addr = AW'($urandom_range(0, 15));
                        dm_addr = AW'($urandom_range(0, 15));
                    end
                end
                check(g, "collision_grants", ngnt == 3, ngnt, 3);
                if_req = 1'b0; dm_req = 1'b0;
                wait_idle();
            end else begin
                if_req = 1'b1; if_addr = 24'h000020;
                drain();
                step(); step();
                rst = 1'b0;
                step(); step();
                rst = 1'b1;
                step();
                if_req = 1'b1; if_addr = 24'h000021;
                drain(); wait_idle();
            end
            repeat (1500) begin
                step();
                if (if_gnt) if_req = 1'b0;
                if (dm_gnt) dm_req = 1'b0;
                if (if_req) begin
                    if ($urandom_range(0, 19) == 0) if_req = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    if_req = 1'b1; if_addr = AW'($urandom_range(0, 15));
                end else begin
                    if_addr = AW'($urandom);
                end
                if (dm_req) begin
                    if ($urandom_range(0, 19) == 0) dm_req = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
                    dm_addr = AW'($urandom_range(0, 15)); dm_wdata = $urandom;
                end else begin
                    dm_we = 1'($urandom); dm_addr = AW'($urandom); dm_wdata = $urandom;
                end
            end
            if_req = 1'b0; dm_req = 1'b0;
            wait_idle();
            repeat (4) step();
            check(g, "queue_empty", q.size() == 0, q.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && !(blk[0].fin && blk[1].fin && blk[2].fin); i++)
            @(posedge clk);
        check(-1, "global_timeout", blk[0].fin && blk[1].fin && blk[2].fin,
              {blk[0].fin, blk[1].fin, blk[2].fin}, 3'b111);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data memory between the fetch requester (PC side) and the load/store requester (data-memory side) of the multi-cycle CPU.
- Runs a small FSM that grants one requester per access.
- Issues a single-cycle memory strobe and waits a fixed memory latency.
- Returns read data with a one-cycle done pulse; the controller stalls on done instead of assuming a fixed memory timing.

Parameters:
ADDR_W, 24, memory word-address width (matches 24-bit instruction address field)
DATA_W, 32, data word width
MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..7

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
if_req  input  1  fetch read request; held with if_addr until if_gnt
if_addr  input  ADDR_W  fetch address
if_gnt  output  1  one-cycle pulse: fetch request accepted
if_done  output  1  one-cycle pulse: if_rdata valid
if_rdata  output  DATA_W  fetched word; held until next if_done
dm_req  input  1  data request; held with dm_we/dm_addr/dm_wdata until dm_gnt
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  store data
dm_gnt  output  1  one-cycle pulse: data request accepted
dm_done  output  1  one-cycle pulse: load data valid or store complete
dm_rdata  output  DATA_W  loaded word; held until next load dm_done
mem_en  output  1  memory strobe, high exactly one cycle per access
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  ADDR_W  memory address, registered
mem_wdata  output  DATA_W  memory write data, registered
mem_rdata  input  DATA_W  memory read data
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including rdata registers and mem_addr/mem_wdata; wait counter 0; RR pointer selects dm. Reset mid-access abandons the access; no done is issued.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any req is high at a clock edge, latch the owner, address, we and wdata.
  - Assert the owner's gnt for the next cycle.
  - Move to ACCESS.
  - With no req, stay in IDLE.
- ACCESS: mem_en=1 and mem_we=latched we for one cycle. Load the counter with MEM_LAT-1. Go to WAIT.
- WAIT: decrement the counter. When it reaches 0 (the edge MEM_LAT cycles after the ACCESS cycle), capture mem_rdata into the owner's rdata register, only for reads. Go to RESP.
- RESP: owner's done=1 for one cycle. Return to IDLE.
- No new request is sampled in RESP.
- Minimum latency, req seen at edge k:
  - gnt and mem_en high in cycle k..k+1.
  - done high in cycle k+MEM_LAT+2.
  - Next grant no earlier than edge k+MEM_LAT+3.
- Fetch accesses always have mem_we=0.
- Stores return dm_done; dm_rdata is unchanged.
- Requests arriving while busy wait.
- A req dropped before its gnt is never serviced.
- After gnt a requester may drop or change req and inputs freely; latched values are used.
- gnt and done never assert for both requesters in the same cycle.
- At most one access is outstanding.
- Arbitration, both reqs high in IDLE (default): dm wins (fixed priority, so a pending load/store finishes before the next fetch).
- Width rules: no address arithmetic; addresses pass through unmodified. mem_rdata is captured as a full DATA_W word.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - On a both-requesting collision, grant the requester not served last.
  - The 1-bit last-served pointer updates on every gnt; reset value = dm served last is false, so dm wins the first collision.
  - Single requests are granted regardless of the pointer.
- Undefined: fixed dm-over-if priority; no pointer register is present.

Test Plan:
- Reset then single fetch: if_req=1, if_addr=24'h000010, mem_rdata=32'hDEADBEEF, MEM_LAT=1.
  - Required: if_gnt and mem_en one cycle after the sampling edge, with mem_addr=24'h000010.
  - Required: if_done 3 cycles after the sampling edge, if_rdata=32'hDEADBEEF, busy low afterwards.
- Store: dm_req=1, dm_we=1, dm_addr=24'h000004, dm_wdata=32'h12345678.
  - Required: one mem_en cycle with mem_we=1 and those address/data values.
  - Required: dm_done pulse with dm_rdata unchanged (0 after reset).
- Collision: if_req and dm_req both high.
  - Without macro: dm granted first, if granted at edge MEM_LAT+3 after.
  - With ARB_ROUND_ROBIN_EN and three back-to-back collisions: grant order dm, if, dm.
- Mid-access reset: drop rst in the WAIT state (MEM_LAT=4).
  - Required: immediate return to zeroed outputs, no done pulse, and a new if_req is serviced normally after release.
- Withdrawn request: dm_req high for one cycle while busy, then low before the state returns to IDLE.
  - Required: no dm_gnt and no memory access for it.
- Load at MEM_LAT=3: mem_rdata presented only on the capture edge.
  - Required: dm_rdata equals that word.
  - Required: mem_en high for exactly one cycle and dm_done 5 cycles after the sampling edge.
